// File: rtl/counter_pkg.sv
// counter_pkg: state encoding shared by the loadable up and down counters
package counter_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/reload_down_timer.sv
// reload_down_timer: loadable down-counting timer with terminal-count pulse and optional auto-reload
module reload_down_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);
  logic [0:0]       state, state_nx;
  logic [WIDTH-1:0] reload_ff, reload_nx, count_nx;
  logic             tc_nx, zero, run, fire, rearm;
  // next state/count/reload with priority load > stop > start > run update
  always_comb begin
    zero      = count == '0;
    run       = state == ST_RUN;
    fire      = run && en && zero && !load && !stop && !start;
    rearm     = auto_reload && reload_ff != '0;
    state_nx  = (load || stop) ? ST_IDLE : start ? ST_RUN : (fire && !rearm) ? ST_IDLE : state;
    count_nx  = load ? load_val : stop ? count : start ? reload_ff :
                (run && en) ? (zero ? (rearm ? reload_ff : count) : count - 1'b1) : count;
    reload_nx = load ? load_val : reload_ff;
    tc_nx     = fire;
  end
  // state, count, reload and tc registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      reload_ff <= '0;
      tc        <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      reload_ff <= reload_nx;
      tc        <= tc_nx;
    end
  end
  assign busy = state == ST_RUN;
endmodule

// File: tb/tb_reload_down_timer.sv
// tb_reload_down_timer: directed scoreboard bench for reload_down_timer
module tb_reload_down_timer;
  logic       clk = 1'b0;
  logic       rst = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, en = 1'b0, auto_reload = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] count;
  logic       tc, busy;

  typedef struct {
    logic [7:0] count;
    logic       tc;
    logic       busy;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0, n_bad = 0;
  logic       m_run = 1'b0, m_tc = 1'b0;
  logic [7:0] m_count = '0, m_reload = '0;

  reload_down_timer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start), .stop(stop),
    .en(en), .auto_reload(auto_reload), .count(count), .tc(tc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [7:0] lv, input logic st,
                      input logic sp, input logic e, input logic ar);
    exp_t x, y;
    @(negedge clk);
    rst = r; load = l; load_val = lv; start = st; stop = sp; en = e; auto_reload = ar;
    m_tc = 1'b0;
    if (r) begin
      m_run = 1'b0; m_count = '0; m_reload = '0;
    end else if (l) begin
      m_reload = lv; m_count = lv; m_run = 1'b0;
    end else if (sp) begin
      m_run = 1'b0;
    end else if (st) begin
      m_count = m_reload; m_run = 1'b1;
    end else if (m_run && e) begin
      if (m_count != 0) m_count = m_count - 8'd1;
      else begin
        m_tc = 1'b1;
        if (ar && m_reload != 0) m_count = m_reload;
        else m_run = 1'b0;
      end
    end
    x.count = m_count; x.tc = m_tc; x.busy = m_run;
    q.push_back(x);
    @(posedge clk);
    #1;
    y = q.pop_front();
    chk("count", 32'(count), 32'(y.count));
    chk("tc", 32'(tc), 32'(y.tc));
    chk("busy", 32'(busy), 32'(y.busy));
  endtask

  initial begin
    int tcs;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1);
    chk("reset_count", 32'(count), 32'd0);
    // periodic, reload 3: four cycles between tc pulses
    step(0, 1, 8'd3, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1, 1);
    tcs = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, 0, 1, 1);
      tcs += int'(tc);
    end
    chk("periodic_tc_count", 32'(tcs), 32'd3);
    // one-shot, reload 5
    step(0, 1, 8'd5, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 1, 0);
    chk("oneshot_idle", 32'({busy, count}), 32'h000);
    // en toggling, reload 4
    step(0, 1, 8'd4, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 14; i++) step(0, 0, 0, 0, 0, i[0] == 1'b0, 0);
    // stop at 5, then restart reloads 8
    step(0, 1, 8'd8, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1, 1);
    chk("stop_holds_5", 32'(count), 32'd5);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1, 1, 1);
    step(0, 0, 0, 1, 0, 1, 1);
    chk("restart_8", 32'(count), 32'd8);
    // load+start mid-run, then reload 0 gives a single tc
    step(0, 1, 8'd9, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 8'h0A, 1, 0, 1, 1);
    chk("load_wins", 32'({busy, count}), 32'h00A);
    step(0, 1, 8'd0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 1);
    // load at the tc cycle suppresses tc
    step(0, 1, 8'd1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 8'd6, 0, 0, 1, 1);
    // rst when count reaches 0
    step(0, 1, 8'd2, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
